// File: rtl/point_double_chain.sv
// Chains k successive doublings of an affine point through one external
// point_double unit, restarting it once per doubling and collecting 2^k*P.
typedef struct packed {
  logic [15:0] x;
  logic [15:0] y;
} curve_point_t;

module point_double_chain #(
  parameter int CNT_WIDTH = 8,
  parameter int GUARD     = 1
) (
  input  logic                 clk,
  input  logic                 Reset_n,
  input  logic                 start,
  input  curve_point_t         P,
  input  logic [CNT_WIDTH-1:0] k,
  output logic                 busy,
  output logic                 Done,
  output curve_point_t         R,
  output logic                 inf,
  output logic                 dbl_reset,
  output curve_point_t         dbl_P,
  input  logic                 dbl_done,
  input  curve_point_t         dbl_R
);

  localparam int GW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_CAPTURE, S_DONE} state_t;

  state_t               state_reg, state_next;
  curve_point_t         cur_reg;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [CNT_WIDTH-1:0] cnt_dec;
  logic                 inf_reg;
  logic [GW-1:0]        guard_reg;
  logic                 accept;
  logic                 accept_done, accept_inf;
  logic                 cap_done, cap_inf;
  logic                 guard_ok;

  assign accept   = start && (state_reg == S_IDLE || state_reg == S_DONE);
  assign cnt_dec  = (cnt_reg == '0) ? '0 : cnt_reg - 1'b1;
  assign guard_ok = (guard_reg >= GW'(GUARD));

  // A zero count finishes with the base point itself; y==0 means 2*P is infinity.
  assign accept_done = (k == '0) || (P.y == '0);
  assign accept_inf  = (k != '0) && (P.y == '0);
  assign cap_done    = (cnt_dec == '0) || (dbl_R.y == '0);
  assign cap_inf     = (cnt_dec != '0) && (dbl_R.y == '0);

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = accept_done ? S_DONE : S_LOAD;
        end
      end
      S_LOAD:    state_next = S_WAIT;
      S_WAIT: begin
        if (dbl_done && guard_ok) begin
          state_next = S_CAPTURE;
        end
      end
      S_CAPTURE: state_next = cap_done ? S_DONE : S_LOAD;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    Done      = 1'b0;
    dbl_reset = 1'b1;
    case (state_reg)
      S_LOAD, S_CAPTURE: busy = 1'b1;
      S_WAIT: begin
        busy      = 1'b1;
        dbl_reset = 1'b0;
      end
      S_DONE:  Done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cur_reg   <= '0;
      cnt_reg   <= '0;
      inf_reg   <= 1'b0;
      guard_reg <= '0;
    end else begin
      if (accept) begin
        cur_reg <= P;
        cnt_reg <= k;
        inf_reg <= accept_inf;
      end else if (state_reg == S_CAPTURE) begin
        cur_reg <= dbl_R;
        cnt_reg <= cnt_dec;
        inf_reg <= cap_inf;
      end
      // The guard window masks a stale done from the previous doubling.
      if (state_reg == S_LOAD) begin
        guard_reg <= '0;
      end else if (state_reg == S_WAIT && !guard_ok) begin
        guard_reg <= guard_reg + 1'b1;
      end
    end
  end

  assign R     = cur_reg;
  assign inf   = inf_reg;
  assign dbl_P = cur_reg;

endmodule

// File: tb/tb_point_double_chain.sv
// Bench for point_double_chain with a stub doubler: R=(x+1,y+2), done 5 cycles
// after dbl_reset falls. Expected results are queued at start, checked at Done.
module tb_point_double_chain;

  logic        clk = 1'b0;
  logic        Reset_n;
  logic        start;
  logic [31:0] P;
  logic [7:0]  k;
  logic        busy, Done, inf, dbl_reset;
  logic [31:0] R, dbl_P, dbl_R;
  logic        dbl_done;

  always #5 clk = ~clk;

  point_double_chain #(.CNT_WIDTH(8), .GUARD(1)) dut (
    .clk(clk), .Reset_n(Reset_n), .start(start), .P(P), .k(k),
    .busy(busy), .Done(Done), .R(R), .inf(inf), .dbl_reset(dbl_reset),
    .dbl_P(dbl_P), .dbl_done(dbl_done), .dbl_R(dbl_R)
  );

  // Stub point_double
  logic [2:0]  stub_cnt = 3'd0;
  logic        stub_done = 1'b0;
  logic [31:0] stub_R = 32'h0;
  logic        inject = 1'b0;

  always @(posedge clk) begin
    if (dbl_reset) begin
      stub_cnt  <= 3'd0;
      stub_done <= 1'b0;
    end else if (stub_cnt < 3'd5) begin
      stub_cnt <= stub_cnt + 3'd1;
      if (stub_cnt == 3'd4) begin
        stub_done <= 1'b1;
        stub_R    <= {dbl_P[31:16] + 16'd1, dbl_P[15:0] + 16'd2};
      end
    end
  end
  assign dbl_done = stub_done | inject;
  assign dbl_R    = stub_R;

  // Count doublings issued (dbl_reset falling) and any low level
  int   n_issue = 0;
  logic lo_seen = 1'b0;
  logic rst_prev = 1'b1;
  always @(negedge clk) begin
    if (rst_prev && !dbl_reset) n_issue++;
    if (!dbl_reset) lo_seen = 1'b1;
    rst_prev = dbl_reset;
  end

  typedef struct {
    logic [31:0] r;
    logic        inf;
    int          cycles;
    int          issued;
  } exp_t;

  exp_t exp_q[$];
  int   vecs = 0;
  int   errs = 0;

  function automatic exp_t model(input logic [15:0] px, input logic [15:0] py, input logic [7:0] kk);
    exp_t        e;
    logic [15:0] x;
    logic [15:0] y;
    int          n;
    x = px; y = py; n = 0; e.inf = 1'b0;
    while (n < int'(kk)) begin
      if (y == 16'd0) begin
        e.inf = 1'b1;
        break;
      end
      x = x + 16'd1;
      y = y + 16'd2;
      n++;
    end
    e.r      = {x, y};
    e.issued = n;
    e.cycles = 1 + 8 * n;
    return e;
  endfunction

  // Called on a negedge; returns on the negedge after start was sampled.
  task automatic send_start(input logic [15:0] px, input logic [15:0] py, input logic [7:0] kk);
    exp_q.push_back(model(px, py, kk));
    n_issue = 0;
    lo_seen = 1'b0;
    P = {px, py};
    k = kk;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int from, output int cycles, output bit ok);
    cycles = from;
    while (!Done && cycles < 400) begin
      @(negedge clk);
      cycles++;
    end
    ok = Done;
  endtask

  task automatic test_reset;
    Reset_n = 1'b0; start = 1'b0; P = 32'h0; k = 8'h0;
    #1;
    if ({busy, Done, inf, dbl_reset, R, dbl_P} !== {4'b0001, 64'h0}) begin
      $display("FAIL reset_state got busy=%b done=%b inf=%b dbl_reset=%b R=%h dbl_P=%h want 0 0 0 1 0 0",
               busy, Done, inf, dbl_reset, R, dbl_P);
      errs++;
    end
    vecs++;
    repeat (3) @(negedge clk);
    Reset_n = 1'b1;
    @(negedge clk);
    $display("reset: busy=%b Done=%b dbl_reset=%b R=%h", busy, Done, dbl_reset, R);
  endtask

  task automatic test_zero_count;
    exp_t e; int cyc; bit ok;
    send_start(16'd3, 16'd7, 8'd0);
    wait_done(1, cyc, ok);
    e = exp_q.pop_front();
    $display("k=0: R=%h inf=%b cycles=%0d", R, inf, cyc);
    if (!ok) begin $display("FAIL k0_timeout got Done=0 want 1"); errs++; end
    vecs++;
    if ({R, inf} !== {e.r, e.inf}) begin
      $display("FAIL k0_result got R=%h inf=%b want R=%h inf=%b", R, inf, e.r, e.inf); errs++;
    end
    vecs++;
    if (cyc !== e.cycles) begin $display("FAIL k0_latency got %0d want %0d", cyc, e.cycles); errs++; end
    vecs++;
    if (lo_seen !== 1'b0) begin $display("FAIL k0_dbl_reset got low=%b want 0", lo_seen); errs++; end
    vecs++;
    P = 32'h00AA_00BB; k = 8'd9;
    repeat (3) @(negedge clk);
    if ({Done, R, inf} !== {1'b1, e.r, e.inf}) begin
      $display("FAIL k0_hold got Done=%b R=%h inf=%b want 1 %h %b", Done, R, inf, e.r, e.inf); errs++;
    end
    vecs++;
  endtask

  task automatic test_chain;
    exp_t e; int cyc; bit ok;
    send_start(16'd3, 16'd7, 8'd3);
    if ({Done, busy} !== 2'b01) begin
      $display("FAIL restart_done_drop got Done=%b busy=%b want 0 1", Done, busy); errs++;
    end
    vecs++;
    wait_done(1, cyc, ok);
    e = exp_q.pop_front();
    $display("k=3: R=%h inf=%b cycles=%0d issued=%0d", R, inf, cyc, n_issue);
    if (!ok) begin $display("FAIL k3_timeout got Done=0 want 1"); errs++; end
    vecs++;
    if ({R, inf, busy} !== {e.r, e.inf, 1'b0}) begin
      $display("FAIL k3_result got R=%h inf=%b busy=%b want R=%h inf=%b busy=0", R, inf, busy, e.r, e.inf); errs++;
    end
    vecs++;
    if (cyc !== e.cycles || n_issue !== e.issued) begin
      $display("FAIL k3_timing got cycles=%0d issued=%0d want %0d %0d", cyc, n_issue, e.cycles, e.issued); errs++;
    end
    vecs++;
  endtask

  task automatic test_busy_ignore;
    exp_t e; int cyc; bit ok;
    send_start(16'd3, 16'd7, 8'd2);
    repeat (3) @(negedge clk);
    start = 1'b1; P = {16'd9, 16'd9}; k = 8'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, cyc, ok);
    e = exp_q.pop_front();
    $display("ignore: R=%h inf=%b cycles=%0d issued=%0d", R, inf, cyc, n_issue);
    if (!ok) begin $display("FAIL ignore_timeout got Done=0 want 1"); errs++; end
    vecs++;
    if ({R, inf} !== {e.r, e.inf} || cyc !== e.cycles || n_issue !== e.issued) begin
      $display("FAIL ignore_result got R=%h inf=%b cycles=%0d issued=%0d want R=%h inf=%b %0d %0d",
               R, inf, cyc, n_issue, e.r, e.inf, e.cycles, e.issued); errs++;
    end
    vecs++;
  endtask

  task automatic test_y_zero;
    exp_t e; int cyc; bit ok;
    send_start(16'd5, 16'd0, 8'd4);
    wait_done(1, cyc, ok);
    e = exp_q.pop_front();
    $display("y=0: R=%h inf=%b cycles=%0d issued=%0d", R, inf, cyc, n_issue);
    if ({ok, R, inf} !== {1'b1, e.r, e.inf}) begin
      $display("FAIL y0_result got Done=%b R=%h inf=%b want 1 %h %b", ok, R, inf, e.r, e.inf); errs++;
    end
    vecs++;
    if (cyc !== e.cycles || lo_seen !== 1'b0) begin
      $display("FAIL y0_no_load got cycles=%0d low=%b want %0d 0", cyc, lo_seen, e.cycles); errs++;
    end
    vecs++;
  endtask

  task automatic test_reset_mid;
    exp_t e; int cyc; bit ok;
    send_start(16'd3, 16'd7, 8'd5);
    void'(exp_q.pop_front());
    repeat (10) @(negedge clk);
    if ({busy, dbl_reset, n_issue} !== {2'b10, 32'd2}) begin
      $display("FAIL mid_pre got busy=%b dbl_reset=%b issued=%0d want 1 0 2", busy, dbl_reset, n_issue); errs++;
    end
    vecs++;
    #1 Reset_n = 1'b0;
    #1;
    if ({busy, Done, inf, dbl_reset, R, dbl_P} !== {4'b0001, 64'h0}) begin
      $display("FAIL mid_reset got busy=%b done=%b inf=%b dbl_reset=%b R=%h dbl_P=%h want 0 0 0 1 0 0",
               busy, Done, inf, dbl_reset, R, dbl_P); errs++;
    end
    vecs++;
    inject = 1'b1;
    repeat (2) @(negedge clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge clk);
    inject = 1'b0;
    if ({busy, Done, dbl_reset, R} !== {3'b001, 32'h0}) begin
      $display("FAIL late_done got busy=%b Done=%b dbl_reset=%b R=%h want 0 0 1 0", busy, Done, dbl_reset, R); errs++;
    end
    vecs++;
    send_start(16'd1, 16'd1, 8'd1);
    wait_done(1, cyc, ok);
    e = exp_q.pop_front();
    $display("after reset: R=%h inf=%b cycles=%0d", R, inf, cyc);
    if ({ok, R, inf} !== {1'b1, e.r, e.inf} || cyc !== e.cycles) begin
      $display("FAIL post_reset got Done=%b R=%h inf=%b cycles=%0d want 1 %h %b %0d",
               ok, R, inf, cyc, e.r, e.inf, e.cycles); errs++;
    end
    vecs++;
  endtask

  task automatic test_inf_after_capture;
    exp_t e; int cyc; bit ok;
    send_start(16'd3, 16'hFFFE, 8'd3);
    wait_done(1, cyc, ok);
    e = exp_q.pop_front();
    $display("inf chain: R=%h inf=%b cycles=%0d issued=%0d", R, inf, cyc, n_issue);
    if ({ok, R, inf} !== {1'b1, e.r, e.inf}) begin
      $display("FAIL capinf_result got Done=%b R=%h inf=%b want 1 %h %b", ok, R, inf, e.r, e.inf); errs++;
    end
    vecs++;
    if (cyc !== e.cycles || n_issue !== e.issued) begin
      $display("FAIL capinf_timing got cycles=%0d issued=%0d want %0d %0d", cyc, n_issue, e.cycles, e.issued); errs++;
    end
    vecs++;
  endtask

  initial begin
    test_reset();
    test_zero_count();
    test_chain();
    test_busy_ignore();
    test_y_zero();
    test_reset_mid();
    test_inf_after_capture();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
